// File: rtl/mvb_chk_pkg.sv
// Shared types and defaults for the MVB loopback frame checker.
package mvb_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_EVAL
    } chk_state_t;

    // Bit positions within err_flags / err_sticky
    localparam int unsigned ERR_CRC       = 0;
    localparam int unsigned ERR_QUALITY   = 1;
    localparam int unsigned ERR_DELIMITER = 2;
    localparam int unsigned ERR_SIGNAL    = 3;
    localparam int unsigned ERR_LENGTH    = 4;
    localparam int unsigned ERR_TIMEOUT   = 5;

    localparam logic [15:0] DEF_FIRST_WORD     = 16'h7EC3;
    localparam int unsigned DEF_FRAME_WORDS    = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 24000;

endpackage

// File: rtl/mvb_sat_cnt.sv
// Saturating up-counter with increment enable.
module mvb_sat_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && cnt != '1) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mvb_frame_checker.sv
// Checks decoded MVB frames against the generator's incrementing pattern.
// Optional receive watchdog enabled by defining MVB_CHK_TIMEOUT_EN.
module mvb_frame_checker
    import mvb_chk_pkg::*;
#(
    parameter logic [15:0] FIRST_WORD     = DEF_FIRST_WORD,
    parameter int unsigned FRAME_WORDS    = DEF_FRAME_WORDS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_valid,
    input  logic [15:0] word,
    input  logic        frame_over,
    input  logic [4:0]  err_flags,
    output logic        frame_done,
    output logic        frame_pass,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt,
    output logic [5:0]  err_sticky,
    output logic [15:0] led
);

    localparam logic [6:0] FRAME_LEN = 7'(FRAME_WORDS);

    chk_state_t  state, state_nxt;
    logic [6:0]  idx, idx_nxt;
    logic        mismatch, mism_nxt;
    logic [4:0]  err_lat, err_nxt;
    logic [15:0] exp_word;
    logic        frame_end, tmo_fire, tmo_reach, verdict;

`ifdef MVB_CHK_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state != ST_RECV || word_valid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign tmo_reach = (state == ST_RECV) && !word_valid &&
                       (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_reach  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Verdict is formed from the next-state frame latches so that a word or
    // error flag in the frame_over cycle still counts toward this frame.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        mism_nxt  = mismatch;
        err_nxt   = err_lat;
        frame_end = 1'b0;
        tmo_fire  = 1'b0;
        exp_word  = FIRST_WORD + 16'(idx);
        unique case (state)
            ST_IDLE, ST_RECV: begin
                if (state == ST_RECV) err_nxt = err_lat | err_flags;
                if (word_valid) begin
                    if (word != exp_word) mism_nxt = 1'b1;
                    if (idx != '1)        idx_nxt  = idx + 7'd1;
                end
                if (frame_over) begin
                    frame_end = 1'b1;
                end else if (tmo_reach) begin
                    frame_end = 1'b1;
                    tmo_fire  = 1'b1;
                end
                if (frame_end)       state_nxt = ST_EVAL;
                else if (word_valid) state_nxt = ST_RECV;
            end
            ST_EVAL: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        verdict = !mism_nxt && (idx_nxt == FRAME_LEN) && (err_nxt == '0) && !tmo_fire;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= '0;
            mismatch   <= 1'b0;
            err_lat    <= '0;
            frame_done <= 1'b0;
            frame_pass <= 1'b0;
            err_sticky <= '0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                idx        <= '0;
                mismatch   <= 1'b0;
                err_lat    <= '0;
                frame_pass <= verdict;
                err_sticky <= err_sticky | {tmo_fire, err_nxt};
            end else begin
                idx      <= idx_nxt;
                mismatch <= mism_nxt;
                err_lat  <= err_nxt;
            end
        end
    end

    mvb_sat_cnt #(.WIDTH(16)) u_pass_cnt (
        .clk (clk),
        .rst (rst),
        .inc (frame_end && verdict),
        .cnt (pass_cnt)
    );

    mvb_sat_cnt #(.WIDTH(16)) u_fail_cnt (
        .clk (clk),
        .rst (rst),
        .inc (frame_end && !verdict),
        .cnt (fail_cnt)
    );

    assign led = {pass_cnt[7:0], fail_cnt[7:0]};

endmodule

// File: tb/tb_mvb_frame_checker.sv
// Randomized and directed bench for mvb_frame_checker with a frame-level model.
module tb_mvb_frame_checker;
    import mvb_chk_pkg::*;

    localparam logic [15:0] FW  = 16'h7EC3;
    localparam int unsigned NW  = 16;
    localparam int unsigned TMO = 24000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        word_valid = 1'b0;
    logic [15:0] word = '0;
    logic        frame_over = 1'b0;
    logic [4:0]  err_flags = '0;
    logic        frame_done, frame_pass;
    logic [15:0] pass_cnt, fail_cnt, led;
    logic [5:0]  err_sticky;

    mvb_frame_checker #(
        .FIRST_WORD     (FW),
        .FRAME_WORDS    (NW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .word_valid (word_valid),
        .word       (word),
        .frame_over (frame_over),
        .err_flags  (err_flags),
        .frame_done (frame_done),
        .frame_pass (frame_pass),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .err_sticky (err_sticky),
        .led        (led)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level reference state
    logic [15:0] m_words[$];
    logic [4:0]  m_errs;
    bit          m_in, m_eval, m_done, m_pass;
    int          m_sil;
    logic [15:0] m_pcnt, m_fcnt;
    logic [5:0]  m_sticky;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_words.delete();
        m_errs = '0; m_in = 0; m_eval = 0; m_done = 0; m_pass = 0; m_sil = 0;
        m_pcnt = '0; m_fcnt = '0; m_sticky = '0;
    endtask

    task automatic check_outputs();
        check("frame_done", frame_done, m_done);
        check("frame_pass", frame_pass, m_pass);
        check("pass_cnt",   pass_cnt,   m_pcnt);
        check("fail_cnt",   fail_cnt,   m_fcnt);
        check("err_sticky", err_sticky, m_sticky);
        check("led",        led,        {m_pcnt[7:0], m_fcnt[7:0]});
    endtask

    // Word i must equal FW+i, with the position saturating at 127.
    task automatic model_finish(input bit tmo);
        bit mism = 0;
        int cnt;
        for (int i = 0; i < m_words.size(); i++)
            if (m_words[i] != FW + 16'((i < 127) ? i : 127)) mism = 1;
        cnt = (m_words.size() > 127) ? 127 : m_words.size();
        m_pass = !mism && (cnt == NW) && (m_errs == 0) && !tmo;
        if (m_pass) begin
            if (m_pcnt != 16'hFFFF) m_pcnt++;
        end else begin
            if (m_fcnt != 16'hFFFF) m_fcnt++;
        end
        m_sticky[4:0] |= m_errs;
        if (tmo) m_sticky[5] = 1'b1;
        m_done = 1; m_eval = 1; m_in = 0;
        m_words.delete();
        m_errs = '0;
    endtask

    // One clock cycle of stimulus; ends at posedge+1 with outputs checked.
    task automatic drive(input logic wv, input logic [15:0] w, input logic fo, input logic [4:0] ef);
        word_valid = wv; word = w; frame_over = fo; err_flags = ef;
        @(posedge clk); #1;
        m_done = 0;
        if (m_eval) begin
            m_eval = 0;
        end else if (!m_in) begin
            if (wv) m_words.push_back(w);
            if (fo) model_finish(0);
            else if (wv) begin m_in = 1; m_sil = 0; end
        end else begin
            m_errs |= ef;
            if (wv) begin m_words.push_back(w); m_sil = 0; end
            else m_sil++;
            if (fo) model_finish(0);
`ifdef MVB_CHK_TIMEOUT_EN
            else if (m_sil == TMO) model_finish(1);
`endif
        end
        check_outputs();
        word_valid = 0; frame_over = 0; err_flags = '0;
    endtask

    function automatic logic [4:0] rand_ef();
        return ($urandom_range(0, 11) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'b0;
    endfunction

    // Contiguous frame followed by the EVAL cycle.
    task automatic send_frame(input int n, input int bad, input logic [4:0] fo_ef, input bit fo_last);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = (i == bad) ? 16'h0000 : FW + 16'(i);
            if (fo_last && i == n - 1) drive(1, w, 1, fo_ef);
            else                       drive(1, w, 0, '0);
        end
        if (!fo_last) drive(0, '0, 1, fo_ef);
        drive(0, '0, 0, '0);
    endtask

    task automatic send_rand_frame();
        int n, bad;
        bit fo_last;
        logic [15:0] w;
        n = ($urandom_range(0, 2) != 0) ? 16 : $urandom_range(13, 19);
        if ($urandom_range(0, 19) == 0) n = 130;
        bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
        fo_last = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) drive(0, 16'($urandom), 0, rand_ef());
            w = FW + 16'(i);
            if (i == bad) w = w ^ 16'(1 << $urandom_range(0, 15));
            if (fo_last && i == n - 1) drive(1, w, 1, rand_ef());
            else                       drive(1, w, 0, rand_ef());
        end
        if (!fo_last) drive(0, 16'($urandom), 1, rand_ef());
        // EVAL slot: any word here must be dropped
        drive(1'($urandom_range(0, 1)), 16'($urandom), 0, rand_ef());
        repeat ($urandom_range(0, 2)) drive(0, 16'($urandom), 0, rand_ef());
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b1;

        // Good frame
        send_frame(16, -1, '0, 0);
        check("led_good", led, 16'h0100);
        // Corrupted word 5
        send_frame(16, 5, '0, 0);
        check("fail_corrupt", fail_cnt, 16'd1);
        check("sticky_corrupt", err_sticky, 6'd0);
        // CRC flag on the frame_over cycle
        send_frame(16, -1, 5'(1 << ERR_CRC), 0);
        check("sticky_crc", err_sticky, 6'd1);
        // Short frame, no flags
        send_frame(15, -1, '0, 0);
        check("short_pass", frame_pass, 1'b0);
        // Last word with frame_over, then back-to-back frame
        send_frame(16, -1, '0, 1);
        send_frame(16, -1, '0, 0);
        check("b2b_pass_cnt", pass_cnt, 16'd3);
        check("b2b_fail_cnt", fail_cnt, 16'd3);

`ifdef MVB_CHK_TIMEOUT_EN
        begin
            bit fired = 0;
            for (int i = 0; i < 3; i++) drive(1, FW + 16'(i), 0, '0);
            for (int c = 0; c < TMO + 10 && !fired; c++) begin
                drive(0, '0, 0, '0);
                fired = m_done;
            end
            check("timeout_fired", fired, 1'b1);
            drive(0, '0, 0, '0);
            check("sticky_timeout", err_sticky[ERR_TIMEOUT], 1'b1);
            drive(0, '0, 1, '0);
            drive(0, '0, 0, '0);
            check("stray_fo_fail", fail_cnt, 16'd5);
        end
`endif

        for (int f = 0; f < 60; f++) send_rand_frame();

        // Reset mid-frame
        for (int i = 0; i < 5; i++) drive(1, FW + 16'(i), 0, '0);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) drive(0, '0, 0, '0);
        send_frame(16, -1, '0, 0);
        check("post_reset_pass", pass_cnt, 16'd1);

        // Saturation of fail_cnt
        force dut.u_fail_cnt.cnt = 16'hFFFE;
        #1;
        release dut.u_fail_cnt.cnt;
        m_fcnt = 16'hFFFE;
        send_frame(16, 3, '0, 0);
        check("sat_reach", fail_cnt, 16'hFFFF);
        send_frame(16, -1, 5'(1 << ERR_LENGTH), 0);
        check("sat_hold", fail_cnt, 16'hFFFF);
        check("sat_sticky", err_sticky[ERR_LENGTH], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mvb_frame_checker.md
# mvb_frame_checker

Receive-side companion to the MVB loopback test harness's frame generator. It consumes the word stream and status flags produced by the MVB decoder, checks each frame against the generator's known incrementing pattern, and keeps pass/fail statistics for the board LEDs. It sits beside the decoder in the loopback test top, clocked from the 24 MHz domain.

## Interface
Parameters:
- FIRST_WORD, 16'h7EC3, expected value of word 0 of every frame
- FRAME_WORDS, 16, expected number of words per frame (1..127)
- TIMEOUT_CYCLES, 24000, watchdog limit in clk cycles; used only with MVB_CHK_TIMEOUT_EN

Ports:
- clk  in  1  24 MHz system clock
- rst  in  1  asynchronous, active-low reset
- word_valid  in  1  one-cycle strobe, word is valid
- word  in  16  decoded data word
- frame_over  in  1  one-cycle strobe, decoder has finished the frame
- err_flags  in  5  {length, signal, delimiter, quality, crc} decoder errors, level or pulse
- frame_done  out  1  one-cycle pulse, frame verdict is valid
- frame_pass  out  1  verdict of the last frame, held until the next frame_done
- pass_cnt  out  16  frames passed, saturating
- fail_cnt  out  16  frames failed, saturating
- err_sticky  out  6  {timeout, length, signal, delimiter, quality, crc}; OR of all failures since reset
- led  out  16  {pass_cnt[7:0], fail_cnt[7:0]}, active-high

## Operation
- The state machine has three states: IDLE, RECV and EVAL.
- IDLE:
  - word_valid moves the block to RECV and that word is checked as index 0.
  - frame_over alone moves the block to EVAL as an empty frame.
  - err_flags are ignored.
- RECV:
  - Each word_valid compares word against (FIRST_WORD + idx) mod 2^16.
  - Any miscompare sets the internal mismatch bit.
  - idx is 7 bits and saturates at 127.
  - err_flags are ORed into the frame error latch every cycle.
  - frame_over moves the block to EVAL.
- EVAL (one cycle):
  - Verdict is pass when mismatch = 0, idx = FRAME_WORDS and the frame error latch = 0.
  - The block pulses frame_done, updates frame_pass, increments pass_cnt or fail_cnt (saturating at 16'hFFFF), and ORs the failure causes into err_sticky.
  - The frame latches are then cleared and the block returns to IDLE.
- Word count errors (idx ≠ FRAME_WORDS) set no err_sticky bit on their own. They are visible only through fail_cnt.
- A word_valid that arrives in EVAL is dropped and counted toward no frame.

## Timing
- Reset values: state IDLE, all counters 0, frame_done 0, frame_pass 0, err_sticky 0, led 0.
- frame_done is asserted exactly 1 cycle after the frame_over cycle. Counters and frame_pass update on that same edge.
- word_valid and frame_over in the same cycle: the word is checked first, and it is included in the verdict.
- err_flags asserted in the frame_over cycle are included in the verdict.
- Back-to-back frames: a word_valid in the cycle after EVAL starts a new frame. The minimum gap between frame_over and the next frame's first word is 1 cycle.
- Saturation: once a counter reaches 16'hFFFF it holds, and err_sticky bits are still updated.
- Reset asserted mid-frame clears all state immediately (asynchronous). No frame_done is produced for the aborted frame.
- Comparator arithmetic is 16-bit unsigned and wraps (16'hFFFF + 1 = 16'h0000).

## Configuration
- MVB_CHK_TIMEOUT_EN defined:
  - A cycle counter runs in RECV and is reset on every word_valid.
  - If it reaches TIMEOUT_CYCLES, the block goes to EVAL and the frame is forced to fail with the timeout bit set.
  - The following frame_over is treated as arriving in IDLE.
- MVB_CHK_TIMEOUT_EN undefined: RECV waits indefinitely, and err_sticky[5] is tied to 0.

## Structure
- Package mvb_chk_pkg holds:
  - the state enum (IDLE, RECV, EVAL)
  - err_flags bit-index constants
  - the default FIRST_WORD, FRAME_WORDS and TIMEOUT_CYCLES values
- One sub-module, mvb_sat_cnt: a parameterised-width saturating counter with an increment enable. It is instantiated twice, for pass_cnt and fail_cnt.

## Test plan
- Good frame: 16 words 7EC3..7ED2 followed by frame_over -> frame_done 1 cycle later, frame_pass=1, pass_cnt=1, led=16'h0100.
- Corrupted word: word 5 = 16'h0000 -> frame_pass=0, fail_cnt=1, err_sticky=0.
- Error flag: good data plus crc flag on the frame_over cycle -> fail, err_sticky[0]=1. Length-only short frame (15 words) -> fail.
- Simultaneous events: 16th word_valid in the same cycle as frame_over -> pass. Next frame starts 1 cycle after EVAL -> second pass, pass_cnt=2.
- Timeout (MVB_CHK_TIMEOUT_EN): 3 words then silence for 24000 cycles -> fail, err_sticky[5]=1. A stray frame_over afterwards -> empty frame, fail_cnt=2.
- Reset and saturation: rst low mid-frame -> all outputs 0 and no frame_done. Preload fail_cnt to FFFF and send a bad frame -> fail_cnt stays FFFF.
